// File: rtl/smps_pkg.sv
// Shared definitions for the switching power stage: gate-drive state encoding
// and default sizing for the PWM period counter and duty clamp.
package smps_pkg;

    // Period counter width; the PWM period is 2**CntWDefault clocks.
    localparam int unsigned CntWDefault    = 8;
    // Largest duty value the modulator will act on; leaves room for dead time.
    localparam int unsigned DutyMaxDefault = 230;
    // Dead-time length in clocks.
    localparam int unsigned DeadCycDefault = 4;

    // Gate-drive states. OFF must stay at zero so a reset register reads as OFF.
    typedef enum logic [2:0] {
        StOff    = 3'd0,
        StLoOn   = 3'd1,
        StDeadLh = 3'd2,
        StHiOn   = 3'd3,
        StDeadHl = 3'd4
    } pwm_state_e;

endpackage

// File: rtl/dead_time_fsm.sv
// Dead-time gate sequencer. Turns the raw PWM compare into a complementary
// high/low gate pair with a fixed break-before-make gap in both directions.
// The low-side gate is additionally qualified by soft-start completion.
module dead_time_fsm
    import smps_pkg::*;
#(
    parameter int unsigned DEAD_CYC = DeadCycDefault
) (
    input  logic i_clk,
    input  logic reset,
    input  logic i_raw,
    input  logic i_enable,
    input  logic i_ss_done,
    output logic o_pwm_hi,
    output logic o_pwm_lo,
    output logic o_active
);

    // Dead counter only needs to hold 0 .. DEAD_CYC-1.
    localparam int unsigned DcntW = (DEAD_CYC > 1) ? $clog2(DEAD_CYC) : 1;
    localparam logic [DcntW-1:0] DeadLoad = DcntW'(DEAD_CYC - 1);

    pwm_state_e       state_q, state_d;
    logic [DcntW-1:0] dcnt_q, dcnt_d;

    // State and dead counter registers.
    always_ff @(posedge i_clk or posedge reset) begin
        if (reset) begin
            state_q <= StOff;
            dcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            dcnt_q  <= dcnt_d;
        end
    end

    // Next-state logic; dropping enable wins over every other transition.
    always_comb begin
        state_d = state_q;
        dcnt_d  = dcnt_q;
        if (!i_enable) begin
            state_d = StOff;
        end else begin
            unique case (state_q)
                StOff: begin
                    state_d = StLoOn;
                end
                StLoOn: begin
                    if (i_raw) begin
                        state_d = StDeadLh;
                        dcnt_d  = DeadLoad;
                    end
                end
                StDeadLh: begin
                    // A high pulse shorter than the dead time is swallowed.
                    if (!i_raw) begin
                        state_d = StLoOn;
                    end else if (dcnt_q == '0) begin
                        state_d = StHiOn;
                    end else begin
                        dcnt_d = dcnt_q - DcntW'(1);
                    end
                end
                StHiOn: begin
                    if (!i_raw) begin
                        state_d = StDeadHl;
                        dcnt_d  = DeadLoad;
                    end
                end
                StDeadHl: begin
                    // Always runs to completion so the low side never overlaps.
                    if (dcnt_q == '0) begin
                        state_d = StLoOn;
                    end else begin
                        dcnt_d = dcnt_q - DcntW'(1);
                    end
                end
                default: begin
                    state_d = StOff;
                end
            endcase
        end
    end

    // Gate outputs decode directly from the state register, so an asynchronous
    // reset clears them without waiting for a clock edge.
    always_comb begin
        o_pwm_hi = (state_q == StHiOn);
        o_pwm_lo = (state_q == StLoOn) && i_ss_done;
        o_active = (state_q != StOff);
    end

endmodule

// File: rtl/pwm_gen.sv
// Complementary PWM modulator for the power stage. Holds the period counter,
// the period-latched duty and the raw compare; the dead-time sequencer turns
// the compare into the high/low gate pair.
module pwm_gen
    import smps_pkg::*;
#(
    parameter int unsigned CNT_W    = CntWDefault,
    parameter int unsigned DEAD_CYC = DeadCycDefault,
    parameter int unsigned DUTY_MAX = DutyMaxDefault
) (
    input  logic             i_clk,
    input  logic             reset,
    input  logic             i_enable,
    input  logic [CNT_W-1:0] i_duty_sel,
    input  logic             i_ss_done,
    output logic             o_pwm_hi,
    output logic             o_pwm_lo,
    output logic             o_period_start
);

    localparam logic [CNT_W-1:0] DutyMaxW = CNT_W'(DUTY_MAX);
    localparam logic [CNT_W-1:0] CntLast  = {CNT_W{1'b1}};

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] duty_lat_q, duty_lat_d;
    logic [CNT_W-1:0] duty_clamped;
    logic             raw;
    logic             active;
    logic             load_duty;

    // Clamp, compare and load qualification.
    always_comb begin
        duty_clamped = (i_duty_sel > DutyMaxW) ? DutyMaxW : i_duty_sel;
        raw          = (cnt_q < duty_lat_q);
        // Load on the last count of a period, or on the OFF -> LO_ON edge, so a
        // new duty always takes effect from cnt == 0.
        load_duty    = i_enable && (!active || (cnt_q == CntLast));
    end

    // Counter and duty next-state; the counter is held at zero while stopped.
    always_comb begin
        cnt_d      = (i_enable && active) ? cnt_q + CNT_W'(1) : '0;
        duty_lat_d = load_duty ? duty_clamped : duty_lat_q;
    end

    // Period counter and latched duty registers.
    always_ff @(posedge i_clk or posedge reset) begin
        if (reset) begin
            cnt_q      <= '0;
            duty_lat_q <= '0;
        end else begin
            cnt_q      <= cnt_d;
            duty_lat_q <= duty_lat_d;
        end
    end

    // Period-start strobe for downstream sampling.
    always_comb begin
        o_period_start = active && (cnt_q == '0);
    end

    dead_time_fsm #(
        .DEAD_CYC (DEAD_CYC)
    ) u_dead_time_fsm (
        .i_clk     (i_clk),
        .reset     (reset),
        .i_raw     (raw),
        .i_enable  (i_enable),
        .i_ss_done (i_ss_done),
        .o_pwm_hi  (o_pwm_hi),
        .o_pwm_lo  (o_pwm_lo),
        .o_active  (active)
    );

endmodule

// File: tb/tb_pwm_gen.sv
// Self-checking bench for pwm_gen. The reference model tracks only the period
// position and latched duty; expected gate levels come from the closed-form
// windows of the waveform (hi for cnt D+1..d, lo off for cnt 1..d+D, etc.).
module tb_pwm_gen;

    localparam int unsigned CW  = 8;
    localparam int unsigned DC  = 4;
    localparam int unsigned DM  = 230;
    localparam int unsigned PER = 256;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic [CW-1:0] sel;
    logic          ss;
    logic          hi;
    logic          lo;
    logic          ps;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    bit          m_run;
    int unsigned m_cnt;
    int unsigned m_duty;

    pwm_gen #(
        .CNT_W    (CW),
        .DEAD_CYC (DC),
        .DUTY_MAX (DM)
    ) dut (
        .i_clk          (clk),
        .reset          (rst),
        .i_enable       (en),
        .i_duty_sel     (sel),
        .i_ss_done      (ss),
        .o_pwm_hi       (hi),
        .o_pwm_lo       (lo),
        .o_period_start (ps)
    );

    always #5 clk = ~clk;

    function automatic int unsigned clamp(input int unsigned v);
        return (v > DM) ? DM : v;
    endfunction

    // Expected {hi, lo, period_start} for the current model position.
    function automatic logic [2:0] expect_out();
        logic e_hi;
        logic e_lo;
        e_hi = m_run && (m_duty > DC) && (m_cnt > DC) && (m_cnt <= m_duty);
        if (!m_run || !ss)        e_lo = 1'b0;
        else if (m_duty == 0)     e_lo = 1'b1;
        else if (m_duty <= DC)    e_lo = !((m_cnt >= 1) && (m_cnt <= m_duty));
        else                      e_lo = !((m_cnt >= 1) && (m_cnt <= m_duty + DC));
        return {e_hi, e_lo, m_run && (m_cnt == 0)};
    endfunction

    // Advance one clock: update the model from the inputs seen at the edge.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            m_run = 1'b0; m_cnt = 0; m_duty = 0;
        end else if (!en) begin
            m_run = 1'b0; m_cnt = 0;
        end else if (!m_run) begin
            m_run = 1'b1; m_cnt = 0; m_duty = clamp(32'(sel));
        end else begin
            if (m_cnt == PER - 1) m_duty = clamp(32'(sel));
            m_cnt = (m_cnt + 1) % PER;
        end
        #2;
    endtask

    // Run until the model sits on the last count of a period (bounded).
    task automatic to_wrap();
        for (int i = 0; i < int'(PER) + 2 && m_cnt != PER - 1; i++) tick();
    endtask

    // Observe one full period starting at the next wrap and gather statistics.
    task automatic measure_period(output int hi_n, output int lo_n, output int gap_n,
                                  output int first_hi, output int last_hi,
                                  output int mism, output int ovl);
        hi_n = 0; lo_n = 0; gap_n = 0; first_hi = -1; last_hi = -1; mism = 0; ovl = 0;
        for (int i = 0; i < int'(PER); i++) begin
            tick();
            if ({hi, lo, ps} !== expect_out()) mism++;
            if (hi && lo) ovl++;
            if (hi) begin
                hi_n++;
                if (first_hi < 0) first_hi = int'(m_cnt);
                last_hi = int'(m_cnt);
            end
            if (lo) lo_n++;
            if (!hi && !lo) gap_n++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; en = 1'b0; sel = '0; ss = 1'b0;
        m_run = 1'b0; m_cnt = 0; m_duty = 0;
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({hi, lo, ps} !== 3'b000) begin
            errors++;
            $display("FAIL reset_outputs: got hi/lo/ps=%b required 000", {hi, lo, ps});
        end
        tick(); tick();
        #1 rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({hi, lo, ps} !== 3'b000) begin
                errors++;
                $display("FAIL idle_off cyc %0d: got hi/lo/ps=%b required 000", i, {hi, lo, ps});
            end
        end
    endtask

    task automatic test_duty128();
        int hn, ln, gn, fh, lh, mm, ov;
        ss = 1'b1; sel = 8'd128; en = 1'b1;
        tick();
        checks++;
        if ({hi, lo, ps} !== 3'b011) begin
            errors++;
            $display("FAIL enable_start: got hi/lo/ps=%b required 011", {hi, lo, ps});
        end
        to_wrap();
        measure_period(hn, ln, gn, fh, lh, mm, ov);
        checks++;
        if (hn != 124) begin errors++; $display("FAIL d128_hi_len: got %0d required 124", hn); end
        checks++;
        if (ln != 124) begin errors++; $display("FAIL d128_lo_len: got %0d required 124", ln); end
        checks++;
        if (gn != 8) begin errors++; $display("FAIL d128_dead_len: got %0d required 8", gn); end
        checks++;
        if (fh != 5) begin errors++; $display("FAIL d128_hi_start: got cnt %0d required 5", fh); end
        checks++;
        if (mm != 0) begin errors++; $display("FAIL d128_wave: got %0d bad cycles required 0", mm); end
        checks++;
        if (ov != 0) begin errors++; $display("FAIL d128_overlap: got %0d cycles required 0", ov); end
    endtask

    task automatic test_short_duty();
        int hn, ln, gn, fh, lh, mm, ov;
        sel = 8'd3;
        to_wrap();
        measure_period(hn, ln, gn, fh, lh, mm, ov);
        checks++;
        if (hn != 0) begin errors++; $display("FAIL d3_hi_len: got %0d required 0", hn); end
        checks++;
        if (ln != 253) begin errors++; $display("FAIL d3_lo_len: got %0d required 253", ln); end
        checks++;
        if (mm != 0) begin errors++; $display("FAIL d3_wave: got %0d bad cycles required 0", mm); end
        sel = 8'd0;
        to_wrap();
        measure_period(hn, ln, gn, fh, lh, mm, ov);
        checks++;
        if (hn != 0) begin errors++; $display("FAIL d0_hi_len: got %0d required 0", hn); end
        checks++;
        if (ln != 256) begin errors++; $display("FAIL d0_lo_len: got %0d required 256", ln); end
    endtask

    task automatic test_clamp();
        int hn, ln, gn, fh, lh, mm, ov;
        sel = 8'd255;
        to_wrap();
        tick();
        to_wrap();
        measure_period(hn, ln, gn, fh, lh, mm, ov);
        checks++;
        if (hn != 226) begin errors++; $display("FAIL clamp_hi_len: got %0d required 226", hn); end
        checks++;
        if (lh != 230) begin errors++; $display("FAIL clamp_hi_end: got cnt %0d required 230", lh); end
        checks++;
        if (mm != 0) begin errors++; $display("FAIL clamp_wave: got %0d bad cycles required 0", mm); end
    endtask

    task automatic test_mid_change();
        int hn, ln, gn, fh, lh, mm, ov;
        int hi_cnt, last;
        sel = 8'd100;
        to_wrap();
        hi_cnt = 0; last = -1; mm = 0;
        for (int i = 0; i < int'(PER); i++) begin
            tick();
            if ({hi, lo, ps} !== expect_out()) mm++;
            if (hi) begin hi_cnt++; last = int'(m_cnt); end
            if (m_cnt == 60) sel = 8'd50;
        end
        checks++;
        if (last != 100) begin errors++; $display("FAIL mid_cur_end: got cnt %0d required 100", last); end
        checks++;
        if (hi_cnt != 96) begin errors++; $display("FAIL mid_cur_len: got %0d required 96", hi_cnt); end
        measure_period(hn, ln, gn, fh, lh, mm, ov);
        checks++;
        if (lh != 50) begin errors++; $display("FAIL mid_next_end: got cnt %0d required 50", lh); end
        checks++;
        if (hn != 46) begin errors++; $display("FAIL mid_next_len: got %0d required 46", hn); end
    endtask

    task automatic test_ss_done();
        int hn, ln, gn, fh, lh, mm, ov;
        int ramp [3] = '{20, 40, 60};
        ss = 1'b0;
        foreach (ramp[k]) begin
            sel = 8'(ramp[k]);
            to_wrap();
            measure_period(hn, ln, gn, fh, lh, mm, ov);
            checks++;
            if (ln != 0) begin errors++; $display("FAIL ss_lo_len d%0d: got %0d required 0", ramp[k], ln); end
            checks++;
            if (hn != ramp[k] - 4) begin
                errors++;
                $display("FAIL ss_hi_len d%0d: got %0d required %0d", ramp[k], hn, ramp[k] - 4);
            end
        end
        for (int i = 0; i < int'(PER) && m_cnt != 150; i++) tick();
        ss = 1'b1;
        #1;
        checks++;
        if (lo !== 1'b1) begin errors++; $display("FAIL ss_rise_lo: got %b required 1", lo); end
        tick();
        checks++;
        if ({hi, lo, ps} !== expect_out()) begin
            errors++;
            $display("FAIL ss_after: got hi/lo/ps=%b required %b", {hi, lo, ps}, expect_out());
        end
    endtask

    task automatic test_enable_drop();
        int hn, ln, gn, fh, lh, mm, ov;
        sel = 8'd128; ss = 1'b1;
        to_wrap();
        for (int i = 0; i < int'(PER) && m_cnt != 50; i++) tick();
        checks++;
        if (hi !== 1'b1) begin errors++; $display("FAIL drop_pre_hi: got %b required 1", hi); end
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({hi, lo, ps} !== 3'b000) begin
                errors++;
                $display("FAIL drop_off cyc %0d: got hi/lo/ps=%b required 000", i, {hi, lo, ps});
            end
        end
        en = 1'b1;
        tick();
        checks++;
        if ({hi, lo, ps} !== 3'b011) begin
            errors++;
            $display("FAIL reenable: got hi/lo/ps=%b required 011", {hi, lo, ps});
        end
        to_wrap();
        measure_period(hn, ln, gn, fh, lh, mm, ov);
        checks++;
        if (mm != 0) begin errors++; $display("FAIL reenable_wave: got %0d bad cycles required 0", mm); end
    endtask

    task automatic test_reset_mid();
        // Reset while in the low-to-high dead gap.
        to_wrap();
        for (int i = 0; i < int'(PER) && m_cnt != 2; i++) tick();
        #1 rst = 1'b1;
        m_run = 1'b0; m_cnt = 0; m_duty = 0;
        #1;
        checks++;
        if ({hi, lo, ps} !== 3'b000) begin
            errors++;
            $display("FAIL rst_dead: got hi/lo/ps=%b required 000", {hi, lo, ps});
        end
        tick();
        #1 rst = 1'b0;
        tick();
        checks++;
        if ({hi, lo, ps} !== 3'b011) begin
            errors++;
            $display("FAIL rst_restart: got hi/lo/ps=%b required 011", {hi, lo, ps});
        end
        // Reset while the high side is on must clear it without a clock edge.
        for (int i = 0; i < int'(PER) && m_cnt != 80; i++) tick();
        checks++;
        if (hi !== 1'b1) begin errors++; $display("FAIL rst_pre_hi: got %b required 1", hi); end
        #1 rst = 1'b1;
        m_run = 1'b0; m_cnt = 0; m_duty = 0;
        #1;
        checks++;
        if ({hi, lo, ps} !== 3'b000) begin
            errors++;
            $display("FAIL rst_hi: got hi/lo/ps=%b required 000", {hi, lo, ps});
        end
        tick();
        #1 rst = 1'b0;
        tick();
        checks++;
        if ({hi, lo, ps} !== expect_out()) begin
            errors++;
            $display("FAIL rst_hi_restart: got hi/lo/ps=%b required %b", {hi, lo, ps}, expect_out());
        end
    endtask

    task automatic test_random();
        int bad = 0;
        int ovl = 0;
        for (int i = 0; i < 6000; i++) begin
            if (en && $urandom_range(0, 299) == 0) en = 1'b0;
            else if (!en && $urandom_range(0, 9) == 0) en = 1'b1;
            if ($urandom_range(0, 63) == 0) sel = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 149) == 0) ss = ~ss;
            tick();
            if ({hi, lo, ps} !== expect_out()) begin
                bad++;
                if (bad <= 5)
                    $display("FAIL random cyc %0d: got hi/lo/ps=%b required %b (cnt %0d duty %0d)",
                             i, {hi, lo, ps}, expect_out(), m_cnt, m_duty);
            end
            if (hi && lo) ovl++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL random_wave: got %0d bad cycles required 0", bad); end
        checks++;
        if (ovl != 0) begin errors++; $display("FAIL random_overlap: got %0d cycles required 0", ovl); end
    endtask

    initial begin
        test_reset();
        test_duty128();
        test_short_duty();
        test_clamp();
        test_mid_change();
        test_ss_done();
        test_enable_drop();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pwm_gen.md
# pwm_gen

Power-stage modulator that consumes the duty command produced by `soft_start` (`o_duty_sel`, `o_enable`, `o_done`). It turns the 8-bit duty select into a complementary high-side/low-side gate pair with a fixed period and programmable dead time. Duty changes take effect only at period boundaries. The low-side (synchronous rectifier) switch stays off until soft start reports done.

## Interface
- `CNT_W`, 8: period counter width; period = 2^CNT_W cycles.
- `DEAD_CYC`, 4: dead-time length in clocks; must be ≥1 and < 2^CNT_W − DUTY_MAX.
- `DUTY_MAX`, 230: clamp applied to the latched duty.
- `i_clk`, input, 1: clock.
- `reset`, input, 1: asynchronous, active-high reset.
- `i_enable`, input, 1: run request (driven from soft_start `o_enable`).
- `i_duty_sel`, input, CNT_W: duty command (from `o_duty_sel`).
- `i_ss_done`, input, 1: soft start complete (from `o_done`); gates the low side.
- `o_pwm_hi`, output, 1: high-side gate.
- `o_pwm_lo`, output, 1: low-side gate.
- `o_period_start`, output, 1: one-cycle pulse while cnt == 0 and running.

## Operation
- Registers: `cnt` (CNT_W), `duty_lat` (CNT_W), `state`, and `dcnt` (dead counter, sized for DEAD_CYC).
- States: OFF, LO_ON, DEAD_LH, HI_ON, DEAD_HL.
- Outputs:
  - `o_pwm_hi` = (state == HI_ON).
  - `o_pwm_lo` = (state == LO_ON) & i_ss_done.
  - Both are low in every other state.
- Raw compare: `raw` = (cnt < duty_lat), combinational.
- Duty load:
  - `duty_lat` ← min(i_duty_sel, DUTY_MAX) on the edge where cnt == 2^CNT_W−1 while running.
  - The same load happens on the OFF→LO_ON edge.
  - The new duty is effective from cnt == 0.
- Counter: free-runs 0 … 2^CNT_W−1 and wraps while state ≠ OFF. It is held at 0 in OFF.
- Transitions, evaluated at each edge:
  - OFF → LO_ON when i_enable = 1.
  - LO_ON → DEAD_LH when raw = 1; dcnt ← DEAD_CYC−1.
  - DEAD_LH → LO_ON when raw = 0 (pulse shorter than the dead time is swallowed).
  - DEAD_LH → HI_ON when dcnt == 0; otherwise dcnt decrements.
  - HI_ON → DEAD_HL when raw = 0; dcnt ← DEAD_CYC−1.
  - DEAD_HL → LO_ON when dcnt == 0. DEAD_HL always runs to completion.
  - Any state → OFF on the edge where i_enable = 0; cnt ← 0.
- Overlap: o_pwm_hi and o_pwm_lo are never high in the same cycle, under any input sequence.

## Timing
- Reset values: state = OFF, cnt = 0, duty_lat = 0, dcnt = 0. All outputs are 0.
- Steady state with duty d > DEAD_CYC (D = DEAD_CYC):
  - Hi is high for cnt = D+1 … d, i.e. d−D cycles.
  - DEAD_HL spans cnt = d+1 … d+D.
  - Lo is high for cnt = d+D+1 … 2^CNT_W−1 plus cnt = 0, i.e. 2^CNT_W−d−D cycles.
  - DEAD_LH spans cnt = 1 … D.
- Short duty, 0 < d ≤ D: hi never asserts; lo drops for cnt = 1 … d.
- Zero duty, d = 0: lo stays high for the whole period (when i_ss_done = 1).
- i_ss_done = 0: lo is forced low combinationally. Hi timing is unchanged.
- i_enable falling: both outputs are 0 from the cycle after the sampling edge, regardless of state.
- i_enable rising: LO_ON with cnt = 0 in the next cycle; o_period_start pulses in that cycle.
- i_duty_sel changing mid-period: no effect until the next wrap.
- Reset asserted mid-pulse: outputs go to 0 immediately (asynchronous).

## Structure
- Shared package `smps_pkg`:
  - state encoding localparams (OFF = 0, LO_ON, DEAD_LH, HI_ON, DEAD_HL);
  - default CNT_W;
  - DUTY_MAX default.
- One natural sub-module, `dead_time_fsm`: takes raw, i_enable, and i_ss_done, and produces the gate outputs. It contains state and dcnt.
- `pwm_gen` itself keeps cnt, duty_lat, the compare, and the period-start logic.

## Test plan
- Duty 128 with D = 4 and i_ss_done = 1 → per period:
  - hi high for exactly 124 cycles starting at cnt 5;
  - lo high for 124 cycles;
  - two 4-cycle dead gaps;
  - never any overlap.
- Duty 3, then duty 0 → hi stays 0. At duty 3, lo is low only for cnt 1–3. At duty 0, lo is continuously high.
- i_duty_sel = 255 → duty clamps to 230, so hi is high 226 cycles per period.
- i_duty_sel changes from 100 to 50 at cnt = 60 → the current period still drops hi at cnt 100 (DEAD_HL from cnt 101). The next period drops hi at cnt 50.
- i_ss_done = 0 during soft_start ramping (soft_start instantiated upstream) → o_pwm_lo stays 0 and hi follows the ramp. Once done rises, lo appears in the same cycle that LO_ON is active.
- i_enable drops during HI_ON, and separately reset is asserted mid-DEAD_LH → both outputs are 0 the next cycle (or immediately for reset). Re-enable restarts with cnt = 0 and an o_period_start pulse.
